// File: rtl/wb_load_align.sv
// Writeback stage: commits ALU results and MIPS32 little-endian aligned loads to the GPR write port.
// Optional load-response timeout is compiled in with `define WB_LOAD_TIMEOUT_EN.
module wb_load_align #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_result,
  input  logic        in_is_load,
  input  logic [2:0]  in_load_op,
  input  logic [1:0]  in_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_in,
  output logic [3:0]  rd_byte_w_en,
  output logic        write,
  output logic        load_err
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LWL = 3'b101;
  localparam logic [2:0] OP_LWR = 3'b110;

  state_t      state, state_nx;
  logic [4:0]  pend_rd, pend_rd_nx;
  logic [2:0]  pend_op, pend_op_nx;
  logic [1:0]  pend_lo, pend_lo_nx;
  logic [4:0]  rd_addr_nx;
  logic [31:0] rd_in_nx;
  logic [3:0]  en_nx;
  logic        write_nx;
  logic        err_nx;
  logic        accept;
  logic        timeout_hit;

  logic [31:0] al_data;
  logic [3:0]  al_en;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign in_ready = (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  // Load alignment works on the latched op/offset and the live memory word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    al_data  = dmem_rdata;
    al_en    = 4'b1111;
    byte_sel = dmem_rdata[{pend_lo, 3'b000} +: 8];
    half_sel = pend_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (pend_op)
      OP_LB:   al_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  al_data = {24'h0, byte_sel};
      OP_LH:   al_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  al_data = {16'h0, half_sel};
      // 3-a equals ~a for a 2-bit offset.
      OP_LWL: begin
        al_data = dmem_rdata << {~pend_lo, 3'b000};
        al_en   = 4'b1111 << ~pend_lo;
      end
      OP_LWR: begin
        al_data = dmem_rdata >> {pend_lo, 3'b000};
        al_en   = 4'b1111 >> pend_lo;
      end
      default: ;
    endcase
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || state != WAIT_MEM) begin
      wait_cnt <= '0;
    end else if (!dmem_rvalid && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    pend_rd_nx = pend_rd;
    pend_op_nx = pend_op;
    pend_lo_nx = pend_lo;
    rd_addr_nx = rd_addr;
    rd_in_nx   = rd_in;
    en_nx      = 4'b0000;
    write_nx   = 1'b0;
    err_nx     = 1'b0;
    case (state)
      WAIT_MEM: begin
        if (dmem_rvalid) begin
          state_nx   = COMMIT;
          rd_addr_nx = pend_rd;
          rd_in_nx   = al_data;
          write_nx   = (pend_rd != 5'd0);
          en_nx      = write_nx ? al_en : 4'b0000;
        end else if (timeout_hit) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
      default: begin
        if (!accept) begin
          state_nx = IDLE;
        end else if (in_is_load) begin
          state_nx   = WAIT_MEM;
          pend_rd_nx = in_rd_addr;
          pend_op_nx = in_load_op;
          pend_lo_nx = in_addr_lo;
        end else begin
          // Writes to r0 still pass through COMMIT but never reach the GPR.
          state_nx   = COMMIT;
          rd_addr_nx = in_rd_addr;
          rd_in_nx   = in_result;
          write_nx   = (in_rd_addr != 5'd0);
          en_nx      = write_nx ? 4'b1111 : 4'b0000;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state        <= IDLE;
      pend_rd      <= '0;
      pend_op      <= '0;
      pend_lo      <= '0;
      rd_addr      <= '0;
      rd_in        <= '0;
      rd_byte_w_en <= '0;
      write        <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state        <= state_nx;
      pend_rd      <= pend_rd_nx;
      pend_op      <= pend_op_nx;
      pend_lo      <= pend_lo_nx;
      rd_addr      <= rd_addr_nx;
      rd_in        <= rd_in_nx;
      rd_byte_w_en <= en_nx;
      write        <= write_nx;
      load_err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_wb_load_align.sv
// Scoreboard bench for wb_load_align: expected GPR writes are queued at stimulus time
// and compared when write is seen; byte enables are checked to be zero on every idle cycle.
module tb_wb_load_align;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_load_op;
  logic [1:0]  in_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_in;
  logic [3:0]  rd_byte_w_en;
  logic        write;
  logic        load_err;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  en;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  wb_load_align #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_result(in_result),
    .in_is_load(in_is_load), .in_load_op(in_load_op), .in_addr_lo(in_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_addr(rd_addr), .rd_in(rd_in), .rd_byte_w_en(rd_byte_w_en),
    .write(write), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference alignment written byte-by-byte from the load definitions.
  function automatic wr_t ref_align(input logic [4:0] rd, input logic [2:0] op,
                                    input logic [1:0] a, input logic [31:0] m);
    wr_t r;
    logic [7:0]  b [4];
    logic [15:0] h;
    int k;
    for (int i = 0; i < 4; i++) b[i] = m[8*i +: 8];
    r.rd = rd; r.data = m; r.en = 4'b1111;
    h = a[1] ? {b[3], b[2]} : {b[1], b[0]};
    case (op)
      3'd0: r.data = {{24{b[a][7]}}, b[a]};
      3'd1: r.data = {24'h0, b[a]};
      3'd2: r.data = {{16{h[15]}}, h};
      3'd3: r.data = {16'h0, h};
      3'd5: begin
        k = 3 - int'(a);
        r.data = '0; r.en = '0;
        for (int i = 0; i < 4; i++)
          if (i >= k) begin r.data[8*i +: 8] = b[i-k]; r.en[i] = 1'b1; end
      end
      3'd6: begin
        r.data = '0; r.en = '0;
        for (int i = 0; i < 4; i++)
          if (i + int'(a) <= 3) begin r.data[8*i +: 8] = b[i+int'(a)]; r.en[i] = 1'b1; end
      end
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (write) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write", {27'h0, rd_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          check("wr_rd_addr", {27'h0, rd_addr}, {27'h0, e.rd});
          check("wr_rd_in", rd_in, e.data);
          check("wr_en", {28'h0, rd_byte_w_en}, {28'h0, e.en});
        end
      end else begin
        check("idle_en", {28'h0, rd_byte_w_en}, 32'h0);
      end
`ifndef WB_LOAD_TIMEOUT_EN
      check("load_err_zero", {31'h0, load_err}, 32'h0);
`endif
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", {31'h0, in_ready}, 32'h1);
  endtask

  // Returns #1 after the accepting edge.
  task automatic send_alu(input logic [4:0] rd, input logic [31:0] res);
    wait_ready();
    in_valid = 1'b1; in_is_load = 1'b0; in_rd_addr = rd; in_result = res;
    in_load_op = 3'($urandom); in_addr_lo = 2'($urandom);
    if (rd != 5'd0) sb_q.push_back('{rd: rd, data: res, en: 4'b1111});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_load(input logic [4:0] rd, input logic [2:0] op, input logic [1:0] a,
                           input logic [31:0] m, input int delay, input wr_t exp);
    wait_ready();
    in_valid = 1'b1; in_is_load = 1'b1; in_rd_addr = rd; in_load_op = op; in_addr_lo = a;
    in_result = 32'hDEAD_BEEF;
    dmem_rvalid = 1'b1; dmem_rdata = ~m;  // must be ignored in the accept cycle
    @(posedge clk); #1;
    in_valid = 1'b0; dmem_rvalid = 1'b0;
    repeat (delay) begin @(posedge clk); #1; end
    dmem_rvalid = 1'b1; dmem_rdata = m;
    if (rd != 5'd0) sb_q.push_back(exp);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
  endtask

  task automatic send_load_ref(input logic [4:0] rd, input logic [2:0] op, input logic [1:0] a,
                               input logic [31:0] m, input int delay);
    send_load(rd, op, a, m, delay, ref_align(rd, op, a, m));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd_addr = '0; in_result = '0; in_is_load = 1'b0;
    in_load_op = '0; in_addr_lo = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", {31'h0, write}, 32'h0);
    check("rst_en", {28'h0, rd_byte_w_en}, 32'h0);
    check("rst_rd_in", rd_in, 32'h0);
    check("rst_rd_addr", {27'h0, rd_addr}, 32'h0);
    check("rst_load_err", {31'h0, load_err}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", {31'h0, in_ready}, 32'h1);

    // Non-load latency: write visible right after the accept edge, gone one cycle later.
    send_alu(5'd5, 32'h1234_5678);
    check("alu_lat_write", {31'h0, write}, 32'h1);
    @(posedge clk); #1;
    check("alu_after_write", {31'h0, write}, 32'h0);
    check("alu_after_en", {28'h0, rd_byte_w_en}, 32'h0);

    // Hand-derived load alignment cases.
    send_load(5'd7, 3'd0, 2'd2, 32'h0080_0000, 0, '{rd: 5'd7, data: 32'hFFFF_FF80, en: 4'b1111});
    send_load(5'd7, 3'd1, 2'd2, 32'h0080_0000, 1, '{rd: 5'd7, data: 32'h0000_0080, en: 4'b1111});
    send_load(5'd8, 3'd2, 2'd2, 32'h8001_0000, 0, '{rd: 5'd8, data: 32'hFFFF_8001, en: 4'b1111});
    send_load(5'd8, 3'd3, 2'd2, 32'h8001_0000, 2, '{rd: 5'd8, data: 32'h0000_8001, en: 4'b1111});
    send_load(5'd9, 3'd5, 2'd1, 32'hAABB_CCDD, 0, '{rd: 5'd9, data: 32'hCCDD_0000, en: 4'b1100});
    send_load(5'd9, 3'd6, 2'd1, 32'hAABB_CCDD, 0, '{rd: 5'd9, data: 32'h00AA_BBCC, en: 4'b0111});
    send_load(5'd10, 3'd5, 2'd0, 32'h1122_3344, 0, '{rd: 5'd10, data: 32'h4400_0000, en: 4'b1000});
    send_load(5'd10, 3'd5, 2'd3, 32'h1122_3344, 0, '{rd: 5'd10, data: 32'h1122_3344, en: 4'b1111});
    send_load(5'd11, 3'd6, 2'd3, 32'h1122_3344, 0, '{rd: 5'd11, data: 32'h0000_0011, en: 4'b0001});
    send_load(5'd11, 3'd7, 2'd2, 32'hCAFE_F00D, 0, '{rd: 5'd11, data: 32'hCAFE_F00D, en: 4'b1111});

    // Back-to-back non-loads: ready must stay high through COMMIT.
    @(posedge clk); #1;
    send_alu(5'd1, 32'h0000_0001);
    check("b2b_ready1", {31'h0, in_ready}, 32'h1);
    send_alu(5'd2, 32'h0000_0002);
    check("b2b_ready2", {31'h0, in_ready}, 32'h1);
    send_alu(5'd3, 32'h0000_0003);
    check("b2b_write3", {31'h0, write}, 32'h1);
    send_alu(5'd0, 32'hFFFF_FFFF);
    check("r0_write", {31'h0, write}, 32'h0);
    check("r0_en", {28'h0, rd_byte_w_en}, 32'h0);

    // Random mix through the reference model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        send_alu(5'($urandom), $urandom);
      else
        send_load_ref(5'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3));
    end

    // Reset while a load is outstanding drops it; a later rvalid must not write.
    wait_ready();
    in_valid = 1'b1; in_is_load = 1'b1; in_rd_addr = 5'd12; in_load_op = 3'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pending_ready", {31'h0, in_ready}, 32'h0);
    reset = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    reset = 1'b0; dmem_rvalid = 1'b0;
    check("post_rst_ready", {31'h0, in_ready}, 32'h1);
    dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("stray_rvalid_write", {31'h0, write}, 32'h0);
    check("stray_rvalid_ready", {31'h0, in_ready}, 32'h1);

    // Load with no response.
    wait_ready();
    in_valid = 1'b1; in_is_load = 1'b1; in_rd_addr = 5'd13; in_load_op = 3'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
    begin
      int n = 0;
      while (!load_err && n < 50) begin @(posedge clk); #1; n++; end
      check("timeout_err", {31'h0, load_err}, 32'h1);
      check("timeout_write", {31'h0, write}, 32'h0);
      @(posedge clk); #1;
      check("timeout_err_pulse", {31'h0, load_err}, 32'h0);
      check("timeout_ready", {31'h0, in_ready}, 32'h1);
    end
`else
    repeat (20) begin @(posedge clk); #1; end
    check("wait_forever_ready", {31'h0, in_ready}, 32'h0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_CAFE;
    sb_q.push_back('{rd: 5'd13, data: 32'h0BAD_CAFE, en: 4'b1111});
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
